// File: rtl/fpm_norm_round.sv
// Result stage of the FP multiplier: normalizes the 48-bit mantissa product, rounds to
// nearest-even, classifies overflow/underflow/zero and packs an IEEE-754 single.
module fpm_norm_round #(
  parameter bit ROUND_EN = 1'b1,
  parameter int EXP_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_in,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [47:0]      mant_in,
  input  logic             zero_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic             ovf,
  output logic             unf
);

  localparam int EA_W = EXP_W + 1;
  localparam int EB_W = EXP_W + 2;
  localparam logic signed [EB_W-1:0] EXP_MAX  = EB_W'(255);
  localparam logic signed [EB_W-1:0] EXP_ZERO = '0;

  logic                   vA_q, vB_q;
  logic                   signA_q, zeroA_q, gA_q, sA_q;
  logic [22:0]            mA_q;
  logic signed [EA_W-1:0] eA_q;
  logic [31:0]            result_q;
  logic                   ovf_q, unf_q;

  logic                   advA, advB;
  logic [22:0]            mA_d;
  logic                   gA_d, sA_d;
  logic signed [EA_W-1:0] eA_d;

  logic                   inc;
  logic [23:0]            sumB;
  logic signed [EB_W-1:0] eB;
  logic [31:0]            result_d;
  logic                   ovf_d, unf_d;

  assign advB      = !vB_q || out_ready;
  assign advA      = !vA_q || advB;
  assign in_ready  = advA;
  assign out_valid = vB_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

  // A product of two normalized mantissas lies in [1,4), so at most a one-bit shift is needed.
  always_comb begin
    mA_d = mant_in[45:23];
    gA_d = mant_in[22];
    sA_d = |mant_in[21:0];
    eA_d = {exp_in[EXP_W-1], exp_in};
    if (mant_in[47]) begin
      mA_d = mant_in[46:24];
      gA_d = mant_in[23];
      sA_d = |mant_in[22:0];
      eA_d = {exp_in[EXP_W-1], exp_in} + EA_W'(1);
    end
  end

  always_comb begin
    inc      = ROUND_EN && gA_q && (sA_q || mA_q[0]);
    sumB     = {1'b0, mA_q} + {23'd0, inc};
    eB       = {eA_q[EA_W-1], eA_q} + {{(EB_W-1){1'b0}}, sumB[23]};
    result_d = {signA_q, eB[7:0], sumB[22:0]};
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    // A rounding carry leaves the low 23 bits of the sum at zero, so no explicit clear is needed.
    if (zeroA_q) begin
      result_d = {signA_q, 31'd0};
    end else if (eB >= EXP_MAX) begin
      result_d = {signA_q, 8'hFF, 23'd0};
      ovf_d    = 1'b1;
    end else if (eB <= EXP_ZERO) begin
      result_d = {signA_q, 31'd0};
      unf_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vA_q     <= 1'b0;
      vB_q     <= 1'b0;
      signA_q  <= 1'b0;
      zeroA_q  <= 1'b0;
      gA_q     <= 1'b0;
      sA_q     <= 1'b0;
      mA_q     <= '0;
      eA_q     <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (advA) begin
        vA_q <= in_valid;
        if (in_valid) begin
          signA_q <= sign_in;
          zeroA_q <= zero_in;
          gA_q    <= gA_d;
          sA_q    <= sA_d;
          mA_q    <= mA_d;
          eA_q    <= eA_d;
        end
      end
      if (advB) begin
        vB_q <= vA_q;
        if (vA_q) begin
          result_q <= result_d;
          ovf_q    <= ovf_d;
          unf_q    <= unf_d;
        end
      end
    end
  end

endmodule
